dcmi_ram_arb: RTL

- Arbitrates the single-port capture SRAM between two requesters.
- Requester 1: the DMA write stream (ram_wr_req/ram_wr_ack side of the pingpong DMA).
- Requester 2: the AHB slave read/write path used by the CPU to fetch captured frames.
- DMA has priority by default. A starvation counter bounds CPU wait time. A saturating stall counter exposes DMA back-pressure to the register block.

---
 rtl/dcmi_ram_arb_pkg.sv | 17 +
 rtl/dcmi_defines.sv | 9 +
 rtl/dcmi_ram_arb.sv | 111 +++++++++++
 3 files changed

// File: rtl/dcmi_ram_arb_pkg.sv
// Types and defaults for the capture SRAM arbiter.
`include "dcmi_defines.sv"

package dcmi_ram_arb_pkg;

  localparam int ADDR_W       = `DMA_ADDR_LEN;
  localparam int MAX_WAIT_DEF = `DCMI_ARB_MAX_WAIT;
  localparam int STALL_W_DEF  = `DCMI_STALL_W;
  localparam int WAIT_W       = 4;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_DMA,
    GNT_CPU
  } grant_e;

endpackage

// File: rtl/dcmi_defines.sv
// Shared dcmi build-time defines: address width and arbiter defaults.
`ifndef DCMI_DEFINES_SV
`define DCMI_DEFINES_SV

`define DMA_ADDR_LEN      12
`define DCMI_ARB_MAX_WAIT 4
`define DCMI_STALL_W      16

`endif

// File: rtl/dcmi_ram_arb.sv
// Single-port capture SRAM arbiter: DMA writes have priority, CPU gets a
// bounded wait, and DMA back-pressure is counted for the register block.
module dcmi_ram_arb
  import dcmi_ram_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int STALL_W  = STALL_W_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               block_en,
  input  logic               stall_clr,
  input  logic               dma_req,
  input  logic [ADDR_W-1:0]  dma_addr,
  input  logic [31:0]        dma_wdata,
  output logic               dma_ack,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [31:0]        cpu_wdata,
  output logic               cpu_ack,
  output logic               cpu_rvld,
  output logic [31:0]        cpu_rdata,
  output logic               ram_cs,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [31:0]        ram_wdata,
  input  logic [31:0]        ram_rdata,
  output logic [STALL_W-1:0] dma_stall_cnt
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic              dma_req_g;
  logic              cpu_req_g;
  logic [WAIT_W-1:0] wait_cnt;
  logic              rd_pend;
  grant_e            grant;

  // Requests are gated so that nothing reaches the SRAM while disabled or in reset.
  assign dma_req_g = dma_req & block_en & rstn;
  assign cpu_req_g = cpu_req & block_en & rstn;

  always_comb begin
    grant = GNT_NONE;
    if (dma_req_g && (!cpu_req_g || (wait_cnt < WAIT_MAX))) begin
      grant = GNT_DMA;
    end else if (cpu_req_g) begin
      grant = GNT_CPU;
    end
  end

  always_comb begin
    dma_ack   = 1'b0;
    cpu_ack   = 1'b0;
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (grant)
      GNT_DMA: begin
        dma_ack   = 1'b1;
        ram_cs    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = dma_addr;
        ram_wdata = dma_wdata;
      end
      GNT_CPU: begin
        cpu_ack   = 1'b1;
        ram_cs    = 1'b1;
        ram_we    = cpu_we;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end
      default: ;
    endcase
  end

  // wait_cnt saturates at MAX_WAIT, so reaching it is what hands the next conflict to the CPU.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt <= '0;
      rd_pend  <= 1'b0;
    end else if (!block_en) begin
      wait_cnt <= '0;
      rd_pend  <= 1'b0;
    end else begin
      if (cpu_req_g && !cpu_ack) begin
        wait_cnt <= (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      rd_pend <= cpu_ack & ~cpu_we;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dma_stall_cnt <= '0;
    end else if (stall_clr) begin
      dma_stall_cnt <= '0;
    end else if (dma_req_g && !dma_ack && (dma_stall_cnt != '1)) begin
      dma_stall_cnt <= dma_stall_cnt + 1'b1;
    end
  end

  // A read still in flight when block_en falls is dropped; the CPU side times out.
  assign cpu_rvld  = rd_pend & block_en;
  assign cpu_rdata = cpu_rvld ? ram_rdata : '0;

endmodule
